// File: rtl/alu_md_pkg.sv
// Shared definitions for the EX-stage ALU with multiply/divide.
// Optional divider: define ALU_DIV_EN to add DIV/DIVU and the S_DIV state.
package alu_md_pkg;

    // MIPS R-type funct codes
    localparam logic [5:0] FN_SLL   = 6'h00;
    localparam logic [5:0] FN_SRL   = 6'h02;
    localparam logic [5:0] FN_SRA   = 6'h03;
    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1A;
    localparam logic [5:0] FN_DIVU  = 6'h1B;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_XOR   = 6'h26;
    localparam logic [5:0] FN_NOR   = 6'h27;
    localparam logic [5:0] FN_SLT   = 6'h2A;
    localparam logic [5:0] FN_SLTU  = 6'h2B;

    // Sequencer states; S_DIV only exists when the divider is built
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
`ifdef ALU_DIV_EN
        S_DIV  = 2'd2,
`endif
        S_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/alu_md_if.sv
// ID/EX -> ALU -> EX/MEM bundle.
// Handshake: an operation transfers on a rising edge where in_valid && in_ready;
// out_valid is a one-cycle pulse with result/zero/ovf/illegal valid in that cycle
// and has no back-pressure. dbg_state mirrors the sequencer state for observation.
interface alu_md_if
    import alu_md_pkg::*;
#(
    parameter int WIDTH = 32
);
    localparam int SHW = $clog2(WIDTH);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] op1;
    logic [WIDTH-1:0] op2;
    logic [5:0]       funct;
    logic [SHW-1:0]   shamt;
    logic             out_valid;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             ovf;
    logic             illegal;
    logic             busy;
    state_t           dbg_state;

    modport master (
        output in_valid, op1, op2, funct, shamt,
        input  in_ready, out_valid, result, zero, ovf, illegal, busy, dbg_state
    );

    modport slave (
        input  in_valid, op1, op2, funct, shamt,
        output in_ready, out_valid, result, zero, ovf, illegal, busy, dbg_state
    );
endinterface

// File: rtl/alu_md_iter.sv
// Iterative multiply/divide datapath: one bit per cycle on operand magnitudes,
// signs re-applied combinationally on the outputs.
// With ALU_DIV_EN defined the same registers also run restoring division.
module alu_md_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             step,
`ifdef ALU_DIV_EN
    input  logic             is_div,
`endif
    input  logic             is_signed,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    output logic             last,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);
    localparam int CW = $clog2(WIDTH);

    // acc_r: product high half / partial remainder; sh_r: multiplier / quotient
    logic [WIDTH-1:0]   acc_r, sh_r, m_r;
    logic [CW-1:0]      cnt_r;
    logic               neg_q_r;
    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH:0]     add_sum;
    logic [2*WIDTH-1:0] prod;

    assign a_neg   = is_signed & op1[WIDTH-1];
    assign b_neg   = is_signed & op2[WIDTH-1];
    assign mag_a   = a_neg ? -op1 : op1;
    assign mag_b   = b_neg ? -op2 : op2;
    assign add_sum = {1'b0, acc_r} + (sh_r[0] ? {1'b0, m_r} : '0);
    assign last    = (cnt_r == CW'(WIDTH - 1));

`ifdef ALU_DIV_EN
    logic             div_r, neg_r_r, dz_r;
    logic [WIDTH-1:0] op1_r;
    logic [WIDTH:0]   shifted, trial;
    assign shifted = {acc_r, sh_r[WIDTH-1]};
    assign trial   = shifted - {1'b0, m_r};
`endif

    // Load magnitudes on start, then one shift-add or shift-subtract per step
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r   <= '0;
            sh_r    <= '0;
            m_r     <= '0;
            cnt_r   <= '0;
            neg_q_r <= 1'b0;
`ifdef ALU_DIV_EN
            div_r   <= 1'b0;
            neg_r_r <= 1'b0;
            dz_r    <= 1'b0;
            op1_r   <= '0;
`endif
        end else if (start) begin
            acc_r   <= '0;
            sh_r    <= mag_a;
            m_r     <= mag_b;
            cnt_r   <= '0;
            neg_q_r <= a_neg ^ b_neg;
`ifdef ALU_DIV_EN
            div_r   <= is_div;
            neg_r_r <= a_neg;
            dz_r    <= (op2 == '0);
            op1_r   <= op1;
`endif
        end else if (step) begin
            cnt_r <= cnt_r + 1'b1;
`ifdef ALU_DIV_EN
            if (div_r) begin
                // borrow in trial[WIDTH] means the divisor did not fit
                acc_r <= trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
                sh_r  <= {sh_r[WIDTH-2:0], ~trial[WIDTH]};
            end else
`endif
            begin
                acc_r <= add_sum[WIDTH:1];
                sh_r  <= {add_sum[0], sh_r[WIDTH-1:1]};
            end
        end
    end

    // Sign fix-up and divide-by-zero override on the final register contents
    always_comb begin
        prod   = neg_q_r ? -{acc_r, sh_r} : {acc_r, sh_r};
        hi_out = prod[2*WIDTH-1:WIDTH];
        lo_out = prod[WIDTH-1:0];
`ifdef ALU_DIV_EN
        if (div_r) begin
            if (dz_r) begin
                lo_out = '1;
                hi_out = op1_r;
            end else begin
                lo_out = neg_q_r ? -sh_r : sh_r;
                hi_out = neg_r_r ? -acc_r : acc_r;
            end
        end
`endif
    end
endmodule

// File: rtl/alu_md_unit.sv
// EX-stage ALU: single-cycle R-type ops plus iterative MULT/MULTU into HI/LO.
// Define ALU_DIV_EN to add DIV/DIVU; otherwise funct 0x1A/0x1B are illegal.
module alu_md_unit
    import alu_md_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic    clk,
    input  logic    rst_n,
    alu_md_if.slave bus
);
    state_t           state_r;
    logic             in_ready_r, busy_r, out_valid_r;
    logic             zero_r, ovf_r, illegal_r;
    logic [WIDTH-1:0] result_r, hi_r, lo_r;
    logic [WIDTH-1:0] alu_res, sum, diff, iter_hi, iter_lo;
    logic             alu_ovf, alu_ill, accept, is_mul, is_div, iter_start, iter_step, iter_last;

    assign accept = bus.in_valid && in_ready_r;
    assign is_mul = (bus.funct == FN_MULT) || (bus.funct == FN_MULTU);
`ifdef ALU_DIV_EN
    assign is_div    = (bus.funct == FN_DIV) || (bus.funct == FN_DIVU);
    assign iter_step = (state_r == S_MUL) || (state_r == S_DIV);
`else
    assign is_div    = 1'b0;
    assign iter_step = (state_r == S_MUL);
`endif
    assign iter_start = accept && (is_mul || is_div);

    alu_md_iter #(.WIDTH(WIDTH)) u_iter (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (iter_start),
        .step      (iter_step),
`ifdef ALU_DIV_EN
        .is_div    (is_div),
`endif
        .is_signed ((bus.funct == FN_MULT) || (bus.funct == FN_DIV)),
        .op1       (bus.op1),
        .op2       (bus.op2),
        .last      (iter_last),
        .hi_out    (iter_hi),
        .lo_out    (iter_lo)
    );

    // Single-cycle result, overflow and legality decode for the current funct
    always_comb begin
        sum     = bus.op1 + bus.op2;
        diff    = bus.op1 - bus.op2;
        alu_res = '0;
        alu_ovf = 1'b0;
        alu_ill = 1'b0;
        case (bus.funct)
            FN_ADD: begin
                alu_res = sum;
                alu_ovf = (bus.op1[WIDTH-1] == bus.op2[WIDTH-1]) && (sum[WIDTH-1] != bus.op1[WIDTH-1]);
            end
            FN_ADDU: alu_res = sum;
            FN_SUB: begin
                alu_res = diff;
                alu_ovf = (bus.op1[WIDTH-1] != bus.op2[WIDTH-1]) && (diff[WIDTH-1] != bus.op1[WIDTH-1]);
            end
            FN_SUBU: alu_res = diff;
            FN_AND:  alu_res = bus.op1 & bus.op2;
            FN_OR:   alu_res = bus.op1 | bus.op2;
            FN_XOR:  alu_res = bus.op1 ^ bus.op2;
            FN_NOR:  alu_res = ~(bus.op1 | bus.op2);
            FN_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(bus.op1) < $signed(bus.op2))};
            FN_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (bus.op1 < bus.op2)};
            FN_SLL:  alu_res = bus.op2 << bus.shamt;
            FN_SRL:  alu_res = bus.op2 >> bus.shamt;
            FN_SRA:  alu_res = $signed(bus.op2) >>> bus.shamt;
            FN_MFHI: alu_res = hi_r;
            FN_MFLO: alu_res = lo_r;
            default: alu_ill = 1'b1;
        endcase
    end

    // Sequencer with registered handshake, result, flags and HI/LO
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= S_IDLE;
            in_ready_r  <= 1'b1;
            busy_r      <= 1'b0;
            out_valid_r <= 1'b0;
            result_r    <= '0;
            zero_r      <= 1'b0;
            ovf_r       <= 1'b0;
            illegal_r   <= 1'b0;
            hi_r        <= '0;
            lo_r        <= '0;
        end else begin
            out_valid_r <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (accept) begin
                        if (is_mul || is_div) begin
`ifdef ALU_DIV_EN
                            state_r <= is_div ? S_DIV : S_MUL;
`else
                            state_r <= S_MUL;
`endif
                            in_ready_r <= 1'b0;
                            busy_r     <= 1'b1;
                        end else begin
                            out_valid_r <= 1'b1;
                            result_r    <= alu_res;
                            zero_r      <= (alu_res == '0);
                            ovf_r       <= alu_ovf;
                            illegal_r   <= alu_ill;
                        end
                    end
                end
`ifdef ALU_DIV_EN
                S_MUL, S_DIV: if (iter_last) state_r <= S_DONE;
`else
                S_MUL: if (iter_last) state_r <= S_DONE;
`endif
                S_DONE: begin
                    hi_r        <= iter_hi;
                    lo_r        <= iter_lo;
                    out_valid_r <= 1'b1;
                    result_r    <= '0;
                    zero_r      <= 1'b1;
                    ovf_r       <= 1'b0;
                    illegal_r   <= 1'b0;
                    in_ready_r  <= 1'b1;
                    busy_r      <= 1'b0;
                    state_r     <= S_IDLE;
                end
                default: state_r <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.busy      = busy_r;
    assign bus.out_valid = out_valid_r;
    assign bus.result    = result_r;
    assign bus.zero      = zero_r;
    assign bus.ovf       = ovf_r;
    assign bus.illegal   = illegal_r;
    assign bus.dbg_state = state_r;
endmodule

// File: tb/tb_alu_md_unit.sv
// Bench for alu_md_unit: reference model predicts each operation when it is
// driven, a negedge monitor pops and compares on every out_valid pulse.
module tb_alu_md_unit;
    import alu_md_pkg::*;

    localparam int W  = 32;
    localparam int EW = W + 3;
    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -64'sd2147483648;

    // clock / reset
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_md_if #(.WIDTH(W)) bus ();
    alu_md_unit #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    // scoreboard: {illegal, ovf, zero, result}
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] mon_e;
    logic [W-1:0]  m_hi = '0;
    logic [W-1:0]  m_lo = '0;
    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // reference model, also tracks HI/LO
    task automatic predict(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [4:0] sh, output logic [EW-1:0] e);
        longint sa, sb, t, q, rm;
        logic [63:0]  p;
        logic [W-1:0] r;
        logic o, il;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r = '0; o = 1'b0; il = 1'b0;
        case (f)
            FN_ADD:   begin t = sa + sb; r = t[W-1:0]; o = (t > SMAX) || (t < SMIN); end
            FN_ADDU:  r = a + b;
            FN_SUB:   begin t = sa - sb; r = t[W-1:0]; o = (t > SMAX) || (t < SMIN); end
            FN_SUBU:  r = a - b;
            FN_AND:   r = a & b;
            FN_OR:    r = a | b;
            FN_XOR:   r = a ^ b;
            FN_NOR:   r = ~(a | b);
            FN_SLT:   r = W'(sa < sb);
            FN_SLTU:  r = W'(a < b);
            FN_SLL:   r = b << sh;
            FN_SRL:   r = b >> sh;
            FN_SRA:   begin t = sb >>> sh; r = t[W-1:0]; end
            FN_MFHI:  r = m_hi;
            FN_MFLO:  r = m_lo;
            FN_MULT:  begin t = sa * sb; p = t; m_hi = p[63:32]; m_lo = p[31:0]; end
            FN_MULTU: begin p = {32'b0, a} * {32'b0, b}; m_hi = p[63:32]; m_lo = p[31:0]; end
`ifdef ALU_DIV_EN
            FN_DIV: begin
                if (b == '0) begin m_lo = '1; m_hi = a; end
                else begin q = sa / sb; rm = sa % sb; m_lo = q[W-1:0]; m_hi = rm[W-1:0]; end
            end
            FN_DIVU: begin
                if (b == '0) begin m_lo = '1; m_hi = a; end
                else begin m_lo = a / b; m_hi = a % b; end
            end
`endif
            default:  il = 1'b1;
        endcase
        e = {il, o, (r == '0), r};
    endtask

    function automatic logic is_md(input logic [5:0] f);
        logic m;
        m = (f == FN_MULT) || (f == FN_MULTU);
`ifdef ALU_DIV_EN
        m = m || (f == FN_DIV) || (f == FN_DIVU);
`endif
        return m;
    endfunction

    // driver: called at a negedge, returns at the negedge after the transfer
    task automatic send(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [4:0] sh);
        logic [EW-1:0] e;
        int g = 0;
        while (!bus.in_ready && g < 200) begin @(negedge clk); g++; end
        if (g >= 200) check("ready_timeout", 64'(bus.in_ready), 64'd1);
        predict(f, a, b, sh, e);
        exp_q.push_back(e);
        bus.in_valid = 1'b1; bus.funct = f; bus.op1 = a; bus.op2 = b; bus.shamt = sh;
        @(negedge clk);
        bus.in_valid = 1'b0;
        if (!is_md(f)) check("lat1_valid", 64'(bus.out_valid), 64'd1);
    endtask

    // after a MULT/DIV transfer: stall length and completion pulse
    task automatic md_wait(input int exp_cycles);
        int c = 0;
        check("md_in_ready_low", 64'(bus.in_ready), 64'd0);
        while (bus.busy && c < 200) begin c++; @(negedge clk); end
        check("md_busy_cycles", 64'(c), 64'(exp_cycles));
        check("md_done_pulse", 64'(bus.out_valid), 64'd1);
    endtask

    function automatic logic [W-1:0] rnd_op();
        case ($urandom_range(0, 4))
            0:       return '0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return W'($urandom_range(0, 15));
            default: return W'($urandom);
        endcase
    endfunction

    // monitor
    always @(negedge clk) begin
        if (rst_n && bus.out_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out", 64'd1, 64'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("result", 64'(bus.result), 64'(mon_e[W-1:0]));
                check("flags_ill_ovf_zero", 64'({bus.illegal, bus.ovf, bus.zero}), 64'(mon_e[EW-1:W]));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] ops[$];
        logic [5:0] f;
        int g;
        bus.in_valid = 1'b0; bus.op1 = '0; bus.op2 = '0; bus.funct = '0; bus.shamt = '0;
        repeat (3) @(negedge clk);
        check("rst_in_ready",  64'(bus.in_ready),  64'd1);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_result",    64'(bus.result),    64'd0);
        check("rst_flags",     64'({bus.zero, bus.ovf, bus.illegal, bus.busy}), 64'd0);
        check("rst_state",     64'(bus.dbg_state), 64'(S_IDLE));
        rst_n = 1'b1;
        @(negedge clk);

        send(FN_MFHI, '0, '0, 5'd0);
        send(FN_ADD,  32'h1, 32'hA, 5'd0);
        send(FN_ADD,  32'h7FFF_FFFF, 32'h1, 5'd0);
        send(FN_ADDU, 32'h7FFF_FFFF, 32'h1, 5'd0);
        send(FN_SUB,  32'h8000_0000, 32'h1, 5'd0);
        send(FN_SRA,  '0, 32'h8000_00F0, 5'd4);
        send(FN_SLT,  32'hFFFF_FFFF, 32'h1, 5'd0);
        send(FN_SLTU, 32'hFFFF_FFFF, 32'h1, 5'd0);

        send(FN_MULT, 32'hFFFF_FFFD, 32'h5, 5'd0);
        md_wait(W + 1);
        send(FN_MFHI, '0, '0, 5'd0);
        send(FN_MFLO, '0, '0, 5'd0);

`ifdef ALU_DIV_EN
        send(FN_DIV, 32'h7, 32'h0, 5'd0);
        md_wait(W + 1);
        send(FN_MFLO, '0, '0, 5'd0);
        send(FN_MFHI, '0, '0, 5'd0);
        send(FN_DIV, 32'hFFFF_FFF9, 32'h2, 5'd0);
        md_wait(W + 1);
        send(FN_MFLO, '0, '0, 5'd0);
        send(FN_MFHI, '0, '0, 5'd0);
        send(FN_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0);
        md_wait(W + 1);
        send(FN_MFLO, '0, '0, 5'd0);
        send(FN_MFHI, '0, '0, 5'd0);
`else
        send(FN_DIV, 32'h7, 32'h2, 5'd0);
        send(FN_MFLO, '0, '0, 5'd0);
`endif
        send(6'h3F, 32'h5, 32'h6, 5'd0);
        send(FN_MFHI, '0, '0, 5'd0);

        // random mix
        ops = '{FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND, FN_OR, FN_XOR, FN_NOR, FN_SLT,
                FN_SLTU, FN_SLL, FN_SRL, FN_SRA, FN_MFHI, FN_MFLO, FN_MULT, FN_MULTU, 6'h3F, FN_DIV};
`ifdef ALU_DIV_EN
        ops.push_back(FN_DIVU);
`endif
        for (int i = 0; i < 40; i++) begin
            f = ops[$urandom_range(0, ops.size() - 1)];
            send(f, rnd_op(), rnd_op(), 5'($urandom_range(0, 31)));
            if (is_md(f)) md_wait(W + 1);
        end

        // reset in the middle of a multiply
        send(FN_MULT, 32'h1234_5678, 32'h9ABC_DEF0, 5'd0);
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        exp_q.delete();
        m_hi = '0;
        m_lo = '0;
        #1;
        check("abort_busy",      64'(bus.busy),      64'd0);
        check("abort_in_ready",  64'(bus.in_ready),  64'd1);
        check("abort_out_valid", 64'(bus.out_valid), 64'd0);
        check("abort_state",     64'(bus.dbg_state), 64'(S_IDLE));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send(FN_MFHI, '0, '0, 5'd0);
        send(FN_MFLO, '0, '0, 5'd0);
        for (int i = 0; i < 12; i++) begin
            case (i % 3)
                0:       f = FN_SUB;
                1:       f = FN_AND;
                default: f = FN_SRA;
            endcase
            check("stream_ready", 64'(bus.in_ready), 64'd1);
            send(f, W'($urandom), W'($urandom), 5'($urandom_range(0, 31)));
        end

        g = 0;
        while (exp_q.size() != 0 && g < 100) begin @(negedge clk); g++; end
        check("drain", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
